// File: rtl/pixel_write_arbiter.sv
// Burst-granting round-robin arbiter that shares the framebuffer pixel-write port
// between the cursor/pen painter (requester 0) and the clear/fill engine (requester 1).

typedef logic [15:0] ILI9341_color_t;

module pixel_write_arbiter #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [1:0]           req_valid,
    input  logic [1:0]           req_last,
    input  logic [X_WIDTH-1:0]   req_x_0,
    input  logic [Y_WIDTH-1:0]   req_y_0,
    input  ILI9341_color_t       req_color_0,
    input  logic [X_WIDTH-1:0]   req_x_1,
    input  logic [Y_WIDTH-1:0]   req_y_1,
    input  ILI9341_color_t       req_color_1,
    output logic [1:0]           req_ready,

    output logic                 wr_valid,
    output logic [X_WIDTH-1:0]   wr_x,
    output logic [Y_WIDTH-1:0]   wr_y,
    output ILI9341_color_t       wr_color,
    output logic                 wr_last,
    input  logic                 wr_ready,

    output logic [1:0]           grant,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_served_q, last_served_d;
    logic   burst_open_q, burst_open_d;
    logic   owner;
    logic   other;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            burst_open_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            burst_open_q  <= burst_open_d;
        end
    end

    // Outputs are forced to their reset values while rst is high so that no
    // beat can be accepted in a cycle the arbiter is about to forget.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        burst_open_d  = burst_open_q;
        owner         = 1'b0;
        other         = 1'b1;
        req_ready     = 2'b00;
        wr_valid      = 1'b0;
        wr_x          = '0;
        wr_y          = '0;
        wr_color      = '0;
        wr_last       = 1'b0;
        grant         = 2'b00;
        busy          = 1'b0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid == 2'b11) begin
                        state_d = last_served_q ? GRANT0 : GRANT1;
                    end else if (req_valid[0]) begin
                        state_d = GRANT0;
                    end else if (req_valid[1]) begin
                        state_d = GRANT1;
                    end
                end

                GRANT0, GRANT1: begin
                    owner     = (state_q == GRANT1);
                    other     = ~owner;
                    grant     = owner ? 2'b10 : 2'b01;
                    busy      = 1'b1;
                    wr_valid  = req_valid[owner];
                    wr_x      = owner ? req_x_1 : req_x_0;
                    wr_y      = owner ? req_y_1 : req_y_0;
                    wr_color  = owner ? req_color_1 : req_color_0;
                    wr_last   = req_last[owner];
                    req_ready = wr_ready ? grant : 2'b00;

                    if (wr_valid && wr_ready) begin
                        if (wr_last) begin
                            last_served_d = owner;
                            burst_open_d  = 1'b0;
                            if (req_valid[other]) begin
                                state_d = other ? GRANT1 : GRANT0;
                            end
                        end else begin
                            burst_open_d = 1'b1;
                        end
                    end else if (!burst_open_q && !req_valid[owner]) begin
                        // Kept the port after a last beat, but no new burst followed.
                        state_d = req_valid[other] ? (other ? GRANT1 : GRANT0) : IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboard bench for pixel_write_arbiter: directed bursts push expected beats,
// a negedge monitor pops and compares every accepted write-port beat.

module tb_pixel_write_arbiter;

    typedef struct packed {
        logic        owner;
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] color;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid0, valid1, last0, last1;
    logic [7:0]  x0, x1;
    logic [8:0]  y0, y1;
    logic [15:0] c0, c1;
    logic [1:0]  req_ready;
    logic        wr_valid, wr_last, wr_ready;
    logic [7:0]  wr_x;
    logic [8:0]  wr_y;
    logic [15:0] wr_color;
    logic [1:0]  grant;
    logic        busy;

    beat_t expQ[$];
    int    total = 0;
    int    bad   = 0;

    pixel_write_arbiter #(.X_WIDTH(8), .Y_WIDTH(9)) dut (
        .clk(clk), .rst(rst),
        .req_valid({valid1, valid0}), .req_last({last1, last0}),
        .req_x_0(x0), .req_y_0(y0), .req_color_0(c0),
        .req_x_1(x1), .req_y_1(y1), .req_color_1(c1),
        .req_ready(req_ready),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .wr_last(wr_last), .wr_ready(wr_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, expected test to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out, expected handshake never came", name);
    endtask

    function automatic beat_t makeBeat(input int n, input int k, input int nBeats,
                                       input logic [7:0] xb, input logic [8:0] yb, input logic [15:0] cb);
        beat_t b;
        b.owner = (n == 1);
        b.x     = xb + 8'(k);
        b.y     = yb + 9'(k);
        b.color = cb + 16'(k);
        b.last  = (k == nBeats - 1);
        return b;
    endfunction

    task automatic pushBurst(input int n, input int nBeats, input logic [7:0] xb,
                             input logic [8:0] yb, input logic [15:0] cb);
        for (int k = 0; k < nBeats; k++) expQ.push_back(makeBeat(n, k, nBeats, xb, yb, cb));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setBeat(input int n, input logic v, input beat_t b);
        if (n == 0) begin
            valid0 = v; x0 = b.x; y0 = b.y; c0 = b.color; last0 = b.last;
        end else begin
            valid1 = v; x1 = b.x; y1 = b.y; c1 = b.color; last1 = b.last;
        end
    endtask

    task automatic setValid(input int n, input logic v);
        if (n == 0) valid0 = v;
        else        valid1 = v;
    endtask

    // Presents a beat and holds it until accepted; returns at the start of the next cycle.
    task automatic offerBeat(input int n, input beat_t b);
        bit accepted;
        accepted = 1'b0;
        setBeat(n, 1'b1, b);
        for (int w = 0; w < 100 && !accepted; w++) begin
            @(negedge clk);
            accepted = req_ready[n];
        end
        if (!accepted) reportTimeout($sformatf("accept req%0d x=%0h", n, b.x));
        nextCycle();
    endtask

    task automatic applyStimulus(input int n, input int nBeats, input logic [7:0] xb, input logic [8:0] yb,
                                 input logic [15:0] cb, input int dropAfter, input int dropCycles);
        for (int k = 0; k < nBeats; k++) begin
            offerBeat(n, makeBeat(n, k, nBeats, xb, yb, cb));
            setValid(n, 1'b0);
            if (k == dropAfter) begin
                repeat (dropCycles) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic waitTransfer(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = wr_valid && wr_ready;
        end
        if (!ok) reportTimeout(name);
    endtask

    task automatic applyReset();
        valid0 = 1'b0;
        valid1 = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected beat: got x=%0h y=%0h grant=%b, expected no transfer", wr_x, wr_y, grant);
            end else begin
                beat_t e;
                e = expQ.pop_front();
                checkOutput("beat", {grant, req_ready, wr_x, wr_y, wr_color, wr_last},
                            {(e.owner ? 2'b10 : 2'b01), (e.owner ? 2'b10 : 2'b01), e.x, e.y, e.color, e.last});
            end
        end
    end

    initial begin
        bit    ok;
        beat_t b;
        logic [1:0] rrGrant;

        rst      = 1'b1;
        wr_ready = 1'b0;
        setBeat(0, 1'b1, makeBeat(0, 0, 1, 8'd10, 9'd20, 16'h1111));
        setBeat(1, 1'b1, makeBeat(1, 0, 1, 8'd30, 9'd40, 16'h2222));

        // reset held two cycles with both requesters valid
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset grant", grant, 2'b00);
            checkOutput("reset wr_valid", wr_valid, 1'b0);
            checkOutput("reset req_ready", req_ready, 2'b00);
        end
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release idle", {grant, busy}, 3'b000);
        @(negedge clk);
        checkOutput("first tie grant", {grant, busy, wr_valid, wr_x, req_ready}, {2'b01, 1'b1, 1'b1, 8'd10, 2'b00});

        // round-robin between continuous 3-beat bursts
        applyReset();
        wr_ready = 1'b1;
        pushBurst(0, 3, 8'h20, 9'h040, 16'h0100);
        pushBurst(1, 3, 8'h30, 9'h050, 16'h0200);
        pushBurst(0, 3, 8'h28, 9'h048, 16'h0300);
        fork
            begin
                applyStimulus(0, 3, 8'h20, 9'h040, 16'h0100, -1, 0);
                applyStimulus(0, 3, 8'h28, 9'h048, 16'h0300, -1, 0);
            end
            applyStimulus(1, 3, 8'h30, 9'h050, 16'h0200, -1, 0);
            begin
                waitTransfer("rr first beat", ok);
                if (ok) begin
                    for (int i = 0; i < 9; i++) begin
                        if (i > 0) @(negedge clk);
                        rrGrant = (i >= 3 && i < 6) ? 2'b10 : 2'b01;
                        checkOutput($sformatf("rr cycle %0d", i), {wr_valid && wr_ready, grant}, {1'b1, rrGrant});
                    end
                end
            end
        join

        // burst lock: owner stalls mid-burst while the other requester waits
        applyReset();
        pushBurst(0, 4, 8'h60, 9'h070, 16'h0400);
        pushBurst(1, 1, 8'h90, 9'h0A0, 16'h0500);
        fork
            applyStimulus(0, 4, 8'h60, 9'h070, 16'h0400, 0, 5);
            applyStimulus(1, 1, 8'h90, 9'h0A0, 16'h0500, -1, 0);
            begin
                waitTransfer("lock first beat", ok);
                if (ok) begin
                    repeat (5) begin
                        @(negedge clk);
                        checkOutput("lock hold", {grant, req_ready[1], wr_valid}, {2'b01, 1'b0, 1'b0});
                    end
                    repeat (3) @(negedge clk);
                    @(negedge clk);
                    checkOutput("lock handoff", grant, 2'b10);
                end
            end
        join

        // backpressure on a single-beat burst at the screen corner
        applyReset();
        wr_ready = 1'b0;
        pushBurst(1, 1, 8'd239, 9'd319, 16'hF800);
        fork
            applyStimulus(1, 1, 8'd239, 9'd319, 16'hF800, -1, 0);
            begin
                @(negedge clk);
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("bp hold", {grant, req_ready, wr_valid, wr_x, wr_y, wr_color, wr_last},
                                {2'b10, 2'b00, 1'b1, 8'd239, 9'd319, 16'hF800, 1'b1});
                end
                nextCycle();
                wr_ready = 1'b1;
                repeat (3) @(negedge clk);
                checkOutput("bp idle", {grant, busy, wr_valid}, 4'b0000);
            end
        join

        // reset in the middle of a burst restores requester 0 priority
        applyReset();
        wr_ready = 1'b1;
        pushBurst(0, 1, 8'h11, 9'h022, 16'h0600);
        applyStimulus(0, 1, 8'h11, 9'h022, 16'h0600, -1, 0);
        repeat (2) nextCycle();
        for (int k = 0; k < 2; k++) begin
            b = makeBeat(1, k, 5, 8'h33, 9'h044, 16'h0700);
            expQ.push_back(b);
            offerBeat(1, b);
        end
        setBeat(1, 1'b1, makeBeat(1, 2, 5, 8'h33, 9'h044, 16'h0700));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst priority", {req_ready, wr_valid}, 3'b000);
        nextCycle();
        rst = 1'b0;
        setBeat(0, 1'b1, makeBeat(0, 0, 1, 8'h66, 9'h077, 16'h0A00));
        setBeat(1, 1'b1, makeBeat(1, 0, 1, 8'h55, 9'h066, 16'h0B00));
        expQ.push_back(makeBeat(0, 0, 1, 8'h66, 9'h077, 16'h0A00));
        expQ.push_back(makeBeat(1, 0, 1, 8'h55, 9'h066, 16'h0B00));
        @(negedge clk);
        checkOutput("rst idle", {grant, busy, wr_valid}, 4'b0000);
        @(negedge clk);
        checkOutput("rst tie", grant, 2'b01);
        nextCycle();
        setValid(0, 1'b0);
        @(negedge clk);
        checkOutput("rst handoff", grant, 2'b10);
        nextCycle();
        setValid(1, 1'b0);

        // same owner issues two single-beat bursts back to back
        applyReset();
        pushBurst(0, 1, 8'h77, 9'h088, 16'h0800);
        pushBurst(0, 1, 8'h78, 9'h089, 16'h0900);
        fork
            begin
                applyStimulus(0, 1, 8'h77, 9'h088, 16'h0800, -1, 0);
                applyStimulus(0, 1, 8'h78, 9'h089, 16'h0900, -1, 0);
            end
            begin
                waitTransfer("regrant first beat", ok);
                if (ok) begin
                    @(negedge clk);
                    checkOutput("regrant consecutive", {wr_valid && wr_ready, grant}, {1'b1, 2'b01});
                end
            end
        join

        repeat (3) nextCycle();
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_write_arbiter.md
# pixel_write_arbiter

Shares the single pixel-write port of the display/framebuffer path between two drawing requesters: requester 0 is the cursor/pen painter and requester 1 is the screen clearer/fill engine. The arbiter grants whole bursts: once a requester owns the port, it keeps it until its `last` beat is accepted. Between bursts, ownership alternates round-robin. It sits between the drawing engines and the ILI9341 write interface and forwards each granted beat (x, y, `ILI9341_color_t`) with a valid/ready handshake.

## Interface
- `X_WIDTH`, default 8: width of x coordinate (240 columns).
- `Y_WIDTH`, default 9: width of y coordinate (320 rows).

Clocking and reset:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.

Requester side, for n = 0, 1:
- `req_valid[n]`  in  1  requester n presents a beat.
- `req_last[n]`  in  1  beat is the final one of the burst.
- `req_x_n`  in  `X_WIDTH`  pixel x.
- `req_y_n`  in  `Y_WIDTH`  pixel y.
- `req_color_n`  in  `ILI9341_color_t`  pixel color.
- `req_ready[n]`  out  1  beat from requester n accepted this cycle when high with `req_valid[n]`.

Write port:
- `wr_valid`  out  1  beat presented to the write port.
- `wr_x`  out  `X_WIDTH`  forwarded coordinate.
- `wr_y`  out  `Y_WIDTH`  forwarded coordinate.
- `wr_color`  out  `ILI9341_color_t`  forwarded color.
- `wr_last`  out  1  forwarded last flag.
- `wr_ready`  in  1  downstream accepts beat.

Status:
- `grant`  out  2  one-hot current owner; 0 when idle.
- `busy`  out  1  high in either GRANT state.

## Operation
- State machine with states IDLE, GRANT0 and GRANT1. A 1-bit register `last_served` holds round-robin priority.
- **IDLE**
  - If only one `req_valid` is high, go to that requester's GRANT state.
  - If both are high, go to the GRANT state of the requester ≠ `last_served`.
  - Otherwise stay in IDLE.
- **GRANTn**
  - Forward requester n: `wr_valid=req_valid[n]`; `wr_x/y/color/last` taken from requester n.
  - `req_ready[n]=wr_ready`; the other requester's `req_ready` = 0.
- **Handshake:** a beat transfers when `wr_valid && wr_ready`. Requesters hold valid and data stable until accepted. The arbiter never reorders, drops or duplicates beats.
- **Burst end:** on transfer of a beat with `req_last[n]=1`, set `last_served<=n`. Next state:
  - GRANT of the other requester if its `req_valid` is high this cycle;
  - else GRANTn if `req_valid[n]` is high (new burst by the same owner);
  - else IDLE.
- **Burst lock:** if requester n deasserts valid mid-burst without `last`, the grant is held. `wr_valid`=0 and the other requester waits.
- **IDLE outputs:** `wr_valid`=0, `wr_x`/`wr_y`/`wr_color`/`wr_last`=0, both `req_ready`=0.
- **Reset values:** state IDLE, `last_served`=1 (requester 0 wins the first tie), `grant`=0, `busy`=0, `wr_valid`=0, all `req_ready`=0, data outputs 0.

## Timing
- Grant decision is registered. A request seen in IDLE at cycle t gets `grant` set at t+1, and its first beat can transfer at t+1.
- The datapath is combinational in GRANT: `wr_*` follow requester inputs in the same cycle, and `req_ready` follows `wr_ready` in the same cycle. There is no extra beat latency.
- Back-to-back bursts from different requesters incur no bubble: the new owner's first beat can transfer on the cycle after the old owner's `last` transfer.
- A single-beat burst (valid and last together) releases the grant after that one transfer.
- If `wr_ready` is low, state and outputs hold indefinitely.
- Reset mid-burst: the next cycle is IDLE with all outputs at reset values. The in-flight burst is abandoned, and a requester must restart it.
- `rst` has priority over all other events in the same cycle.

## Test plan
- **Reset:** assert `rst` 2 cycles with both requesters valid. Required: `grant`=0, `wr_valid`=0, `req_ready`=00 during reset. After release, `grant`=01 one cycle later.
- **Tie / round-robin:** both requesters issue 3-beat bursts continuously, `wr_ready`=1. Required: wr beats ordered 0,0,0,1,1,1,0,0,0; `grant` alternates 01→10→01 with no idle cycle between bursts.
- **Burst lock:** requester 0 sends beat 1 of 4, drops valid for 5 cycles while requester 1 is valid. Required: `grant` stays 01, `req_ready[1]`=0 and `wr_valid`=0 in those cycles; the burst completes, then `grant`=10.
- **Backpressure:** requester 1 sends a single beat (x=239, y=319, color=16'hF800, last=1) with `wr_ready` low for 4 cycles. Required: `wr_*` stable with those values and `req_ready[1]`=0 until `wr_ready`=1. Exactly one transfer, then IDLE.
- **Reset mid-burst:** `rst` asserted after beat 2 of 5 from requester 1. Required: next cycle IDLE, `grant`=0, `last_served`=1. After release, requester 0 wins a tie.
- **Same-owner re-grant:** requester 0 issues two single-beat bursts back to back, requester 1 idle. Required: `grant` stays 01 and the two beats transfer on consecutive cycles.
